step_sequencer: RTL and testbench

Multi-cycle instruction control unit for the SimpleProcessor datapath.
- Accepts one instruction at a time over a valid/ready handshake and latches it.
- Drives a one-hot step register through the instruction's execution steps.
- Decodes (opcode, step) into datapath enables for register file, accumulator A, ALU result register G and immediate bus driver.
- Signals completion, halt and illegal-opcode status back to the fetch side.

---
 rtl/sp_ctrl_pkg.sv | 43 ++++
 rtl/step_ring.sv | 34 +++
 rtl/step_sequencer.sv | 168 ++++++++++++++++
 tb/tb_step_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ctrl_pkg.sv
// rtl/sp_ctrl_pkg.sv - shared types, field positions and step counts for the instruction controller
//
// Contents:
//   opcode_t  : 3-bit opcode encoding, MV..ILL
//   state_t   : controller states IDLE, EXEC, HALTED
//   *_HI/_LO  : bit positions of the instruction fields
//   op_len()  : number of execution steps an opcode needs
package sp_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MV   = 3'd0,
        OP_MVI  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_NOP  = 3'd5,
        OP_HALT = 3'd6,
        OP_ILL  = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam int OPC_HI = 8;
    localparam int OPC_LO = 6;
    localparam int RX_HI  = 5;
    localparam int RX_LO  = 3;
    localparam int RY_HI  = 2;
    localparam int RY_LO  = 0;

    // The ALU ops need operand fetch, compute and write-back; everything
    // else finishes in a single step.
    function automatic int unsigned op_len(opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_AND: op_len = 3;
            default:                op_len = 1;
        endcase
    endfunction

endpackage

// File: rtl/step_ring.sv
// rtl/step_ring.sv - one-hot execution step register
//
// Ports:
//   clock   : rising-edge clock
//   reset   : asynchronous active-high reset, clears the ring
//   clear   : load all zeros (highest priority)
//   start   : load step 0 (bit 0 set)
//   advance : shift the hot bit up by one
//   step    : current one-hot step, all zeros when idle
// With no control asserted the register holds.
module step_ring #(
    parameter int STEPS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic             advance,
    output logic [STEPS-1:0] step
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step <= '0;
        end else if (clear) begin
            step <= '0;
        end else if (start) begin
            step <= {{(STEPS-1){1'b0}}, 1'b1};
        end else if (advance) begin
            step <= {step[STEPS-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - multi-cycle instruction control unit for the SimpleProcessor datapath
//
// Ports:
//   clock, reset             : rising-edge clock, asynchronous active-high reset
//   instr_valid/instr_ready  : fetch-side handshake, instr is latched into ir on acceptance
//   stall                    : freezes the current step and gates all enables
//   step                     : one-hot execution step, zero outside EXEC
//   ir                       : latched instruction
//   rf_oe, src_sel, imm_oe   : bus source controls (register file, rx/ry select, immediate)
//   a_load, g_load, g_oe     : accumulator A and result register G controls
//   rf_we                    : write bus into register rx
//   alu_op                   : ALU function for ADD/SUB/AND, zero otherwise
//   done, illegal, halted    : completion, opcode-7 flag and halted status
import sp_ctrl_pkg::*;

module step_sequencer #(
    parameter int IR_W  = 9,
    parameter int STEPS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [IR_W-1:0]  instr,
    input  logic             stall,
    output logic [STEPS-1:0] step,
    output logic [IR_W-1:0]  ir,
    output logic             rf_oe,
    output logic             src_sel,
    output logic             imm_oe,
    output logic             a_load,
    output logic             g_load,
    output logic             g_oe,
    output logic             rf_we,
    output logic [1:0]       alu_op,
    output logic             done,
    output logic             illegal,
    output logic             halted
);

    state_t           state_q;
    state_t           state_d;
    opcode_t          op;
    logic [STEPS-1:0] last_mask;
    logic             is_last;
    logic             ring_clear;
    logic             ring_start;
    logic             ring_advance;

    assign op = opcode_t'(ir[OPC_HI:OPC_LO]);

    // Bit of the step ring that marks the final step of the current opcode.
    assign last_mask = {{(STEPS-1){1'b0}}, 1'b1} << (op_len(op) - 1);
    assign is_last   = |(step & last_mask);

    step_ring #(
        .STEPS (STEPS)
    ) u_ring (
        .clock   (clock),
        .reset   (reset),
        .clear   (ring_clear),
        .start   (ring_start),
        .advance (ring_advance),
        .step    (step)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir <= '0;
        end else if (ring_start) begin
            ir <= instr;
        end
    end

    always_comb begin
        state_d      = state_q;
        instr_ready  = 1'b0;
        ring_clear   = 1'b0;
        ring_start   = 1'b0;
        ring_advance = 1'b0;
        rf_oe        = 1'b0;
        src_sel      = 1'b0;
        imm_oe       = 1'b0;
        a_load       = 1'b0;
        g_load       = 1'b0;
        g_oe         = 1'b0;
        rf_we        = 1'b0;
        alu_op       = 2'b00;
        done         = 1'b0;
        illegal      = 1'b0;
        halted       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                instr_ready = !stall;
                if (instr_valid && !stall) begin
                    ring_start = 1'b1;
                    state_d    = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // A stalled step produces no enables and does not move.
                if (!stall) begin
                    if (is_last) begin
                        done       = 1'b1;
                        illegal    = (op == OP_ILL);
                        ring_clear = 1'b1;
                        state_d    = (op == OP_HALT) ? ST_HALTED : ST_IDLE;
                    end else begin
                        ring_advance = 1'b1;
                    end

                    case (op)
                        OP_MV: begin
                            if (step[0]) begin
                                rf_oe   = 1'b1;
                                src_sel = 1'b1;
                                rf_we   = 1'b1;
                            end
                        end
                        OP_MVI: begin
                            if (step[0]) begin
                                imm_oe = 1'b1;
                                rf_we  = 1'b1;
                            end
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            alu_op = ir[OPC_LO+1:OPC_LO];
                            if (step[0]) begin
                                rf_oe  = 1'b1;
                                a_load = 1'b1;
                            end
                            if (step[1]) begin
                                rf_oe   = 1'b1;
                                src_sel = 1'b1;
                                g_load  = 1'b1;
                            end
                            if (step[2]) begin
                                g_oe  = 1'b1;
                                rf_we = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            ST_HALTED: begin
                halted = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - self-checking bench for step_sequencer against a step-count reference model
module tb_step_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       stall = 1'b0;
    logic [8:0] instr = '0;

    logic       instr_ready;
    logic [3:0] step;
    logic [8:0] ir;
    logic       rf_oe, src_sel, imm_oe, a_load, g_load, g_oe, rf_we;
    logic [1:0] alu_op;
    logic       done, illegal, halted;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 = idle, 1 = busy, 2 = halted; k = step index.
    int         mode = 0;
    int         k = 0;
    logic [8:0] m_ir = '0;
    int         lens [8] = '{1, 1, 3, 3, 3, 1, 1, 1};

    step_sequencer #(
        .IR_W  (9),
        .STEPS (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .stall       (stall),
        .step        (step),
        .ir          (ir),
        .rf_oe       (rf_oe),
        .src_sel     (src_sel),
        .imm_oe      (imm_oe),
        .a_load      (a_load),
        .g_load      (g_load),
        .g_oe        (g_oe),
        .rf_we       (rf_we),
        .alu_op      (alu_op),
        .done        (done),
        .illegal     (illegal),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int         op;
        bit         act;
        logic [3:0] e_step;
        logic       e_rf_oe, e_src, e_imm, e_a, e_gl, e_goe, e_we, e_done, e_ill;
        logic [1:0] e_alu;
        op  = int'(m_ir[8:6]);
        act = (mode == 1) && !stall;
        e_step = (mode == 1) ? 4'(1 << k) : 4'd0;
        {e_rf_oe, e_src, e_imm, e_a, e_gl, e_goe, e_we} = '0;
        e_alu = 2'b00;
        if (act) begin
            if (op == 0 && k == 0) {e_rf_oe, e_src, e_we} = 3'b111;
            if (op == 1 && k == 0) {e_imm, e_we} = 2'b11;
            if (op >= 2 && op <= 4) begin
                e_alu = m_ir[7:6];
                if (k == 0) {e_rf_oe, e_a} = 2'b11;
                if (k == 1) {e_rf_oe, e_src, e_gl} = 3'b111;
                if (k == 2) {e_goe, e_we} = 2'b11;
            end
        end
        e_done = act && (k == lens[op] - 1);
        e_ill  = e_done && (op == 7);
        check("step", step, e_step);
        check("ir", ir, m_ir);
        check("instr_ready", instr_ready, (mode == 0) && !stall);
        check("rf_oe", rf_oe, e_rf_oe);
        check("src_sel", src_sel, e_src);
        check("imm_oe", imm_oe, e_imm);
        check("a_load", a_load, e_a);
        check("g_load", g_load, e_gl);
        check("g_oe", g_oe, e_goe);
        check("rf_we", rf_we, e_we);
        check("alu_op", alu_op, e_alu);
        check("done", done, e_done);
        check("illegal", illegal, e_ill);
        check("halted", halted, mode == 2);
    endtask

    task automatic model_edge();
        int op;
        op = int'(m_ir[8:6]);
        case (mode)
            0: if (instr_valid && !stall) begin
                m_ir = instr;
                k    = 0;
                mode = 1;
            end
            1: if (!stall) begin
                if (k == lens[op] - 1) mode = (op == 6) ? 2 : 0;
                else k++;
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic v, input logic [8:0] ins, input logic st);
        @(negedge clock);
        instr_valid = v;
        instr       = ins;
        stall       = st;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
    endtask

    task automatic cycle(input logic v, input logic [8:0] ins, input logic st);
        drive(v, ins, st);
        tick();
    endtask

    task automatic async_reset();
        @(negedge clock);
        instr_valid = 1'b0;
        stall       = 1'b0;
        #1;
        check_all();
        #1;
        reset = 1'b1;
        mode  = 0;
        k     = 0;
        m_ir  = '0;
        #1;
        check_all();
        check("rst_step_now", step, 4'b0000);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_all();
        check("rst_ready", instr_ready, 1'b1);
        check("rst_halted", halted, 1'b0);
        @(posedge clock);
        model_edge();
    endtask

    initial begin
        #2;
        check_all();
        check("init_step", step, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);

        async_reset();

        // MV
        cycle(1'b1, 9'b000_010_101, 1'b0);
        drive(1'b0, 9'd0, 1'b0);
        check("mv_step", step, 4'b0001);
        check("mv_rf_oe", rf_oe, 1'b1);
        check("mv_src_sel", src_sel, 1'b1);
        check("mv_rf_we", rf_we, 1'b1);
        check("mv_done", done, 1'b1);
        tick();
        drive(1'b0, 9'd0, 1'b0);
        check("mv_after_step", step, 4'b0000);
        check("mv_after_ready", instr_ready, 1'b1);
        tick();

        // ADD with a two-cycle stall on step 1
        cycle(1'b1, 9'b010_001_011, 1'b0);
        cycle(1'b0, 9'd0, 1'b0);
        drive(1'b1, 9'b001_111_111, 1'b1);
        check("add_stall_step", step, 4'b0010);
        check("add_stall_gload", g_load, 1'b0);
        tick();
        drive(1'b0, 9'd0, 1'b1);
        check("add_stall2_step", step, 4'b0010);
        tick();
        drive(1'b0, 9'd0, 1'b0);
        check("add_gload", g_load, 1'b1);
        check("add_alu_op", alu_op, 2'b10);
        check("add_not_done", done, 1'b0);
        tick();
        drive(1'b0, 9'd0, 1'b0);
        check("add_last_step", step, 4'b0100);
        check("add_done", done, 1'b1);
        tick();
        cycle(1'b0, 9'd0, 1'b0);

        // HALT
        cycle(1'b1, 9'b110_000_000, 1'b0);
        drive(1'b0, 9'd0, 1'b0);
        check("halt_done", done, 1'b1);
        tick();
        drive(1'b1, 9'b000_001_001, 1'b0);
        check("halted", halted, 1'b1);
        check("halted_ready", instr_ready, 1'b0);
        tick();
        cycle(1'b1, 9'b000_001_001, 1'b0);
        async_reset();

        // Opcode 7 then a normal instruction
        cycle(1'b1, 9'b111_000_000, 1'b0);
        drive(1'b0, 9'd0, 1'b0);
        check("ill_done", done, 1'b1);
        check("ill_flag", illegal, 1'b1);
        tick();
        cycle(1'b1, 9'b001_100_011, 1'b0);
        drive(1'b0, 9'd0, 1'b0);
        check("post_ill_imm", imm_oe, 1'b1);
        check("post_ill_ir", ir, 9'b001_100_011);
        tick();

        // Asynchronous reset in the middle of an ADD
        cycle(1'b1, 9'b010_001_011, 1'b0);
        cycle(1'b0, 9'd0, 1'b0);
        async_reset();
        cycle(1'b0, 9'd0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                async_reset();
            end else begin
                cycle($urandom_range(0, 9) < 7, 9'($urandom), $urandom_range(0, 3) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
